ntt_bitrev_reorder: RTL and testbench

NTT_BITREV_REORDER -- requirements
Module: ntt_bitrev_reorder

---
 rtl/ntt_pkg.sv | 9 +
 rtl/bitreverse.sv | 13 +
 rtl/ntt_reorder_bank.sv | 56 +++++
 rtl/ntt_bitrev_reorder.sv | 145 ++++++++++++++
 tb/tb_ntt_bitrev_reorder.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT constants: coefficient width and bank read latency defaults.
package ntt_pkg;

  localparam int unsigned LOGQ_DEFAULT       = 32;
  localparam int unsigned DELAY_BRAM_DEFAULT = 1;

  typedef logic [LOGQ_DEFAULT-1:0] coeff_t;

endpackage

// File: rtl/bitreverse.sv
// Combinational bit reversal of a WIDTH-bit index.
module bitreverse #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    assign out_o[g] = in_i[WIDTH-1-g];
  end

endmodule

// File: rtl/ntt_reorder_bank.sv
// Ping-pong coefficient storage: simple dual-port RAM, 2*N words addressed {bank, addr},
// one write port and a registered read port with 1 or 2 cycles of latency.
module ntt_reorder_bank #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned AW      = 11,
  parameter int unsigned LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [WIDTH-1:0] mem_q [Depth];
  logic [WIDTH-1:0] rdata_q;

  // Array write; contents are never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read; the output register clears on reset so out_data reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  if (LATENCY == 2) begin : g_lat2
    logic [WIDTH-1:0] rdata2_q;

    // Extra output pipeline stage for the two-cycle bank.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata2_q <= '0;
      end else begin
        rdata2_q <= rdata_q;
      end
    end

    assign rdata_o = rdata2_q;
  end else begin : g_lat1
    assign rdata_o = rdata_q;
  end

endmodule

// File: rtl/ntt_bitrev_reorder.sv
// Converts a bit-reversed coefficient stream into natural order using two ping-pong banks.
// The writer scatters each sample to bitrev(wcnt); the reader streams a full bank linearly.
// Optional feature: define NTT_REORDER_BYPASS_EN to add a per-block 'bypass' input that
// selects natural write addressing for that block.
module ntt_bitrev_reorder
  import ntt_pkg::*;
#(
  parameter int unsigned LOGQ       = LOGQ_DEFAULT,
  parameter int unsigned LOGN       = 10,
  parameter int unsigned DELAY_BRAM = DELAY_BRAM_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [LOGQ-1:0] in_data,
`ifdef NTT_REORDER_BYPASS_EN
  input  logic            bypass,
`endif
  output logic            out_valid,
  output logic [LOGQ-1:0] out_data,
  output logic            out_last,
  output logic            busy
);

  typedef enum logic [0:0] {StIdle, StRead} rd_state_e;

  localparam logic [LOGN-1:0] LastAddr = {LOGN{1'b1}};

  logic            wr_en, arm;
  logic [LOGN-1:0] wcnt_q, wcnt_d, wcnt_rev, waddr;
  logic            wsel_q, wsel_d;

  rd_state_e             state_q;
  logic [LOGN-1:0]       rcnt_q;
  logic                  rd_en, rd_last;
  logic [DELAY_BRAM-1:0] vld_q, last_q;

  // Samples arriving during reset are dropped.
  assign wr_en   = in_valid & ~rst;
  assign arm     = wr_en & (wcnt_q == LastAddr);
  assign rd_en   = (state_q == StRead);
  assign rd_last = rd_en & (rcnt_q == LastAddr);

  bitreverse #(
    .WIDTH(LOGN)
  ) u_bitrev (
    .in_i (wcnt_q),
    .out_o(wcnt_rev)
  );

`ifdef NTT_REORDER_BYPASS_EN
  logic byp_q, byp_now;

  // The first sample of a block decides its mode; later samples reuse the latched choice.
  assign byp_now = (wcnt_q == '0) ? bypass : byp_q;
  assign waddr   = byp_now ? wcnt_q : wcnt_rev;

  // Latch the block's bypass mode on its first accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      byp_q <= 1'b0;
    end else if (wr_en && (wcnt_q == '0)) begin
      byp_q <= bypass;
    end
  end
`else
  assign waddr = wcnt_rev;
`endif

  // Writer next state: count accepted samples, swap banks when a block completes.
  always_comb begin
    wcnt_d = wcnt_q;
    wsel_d = wsel_q;
    if (wr_en) begin
      wcnt_d = wcnt_q + 1'b1;
      if (arm) begin
        wsel_d = ~wsel_q;
      end
    end
  end

  // Writer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q <= '0;
      wsel_q <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      wsel_q <= wsel_d;
    end
  end

  // Reader FSM plus the valid/last pipeline matching the bank read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rcnt_q  <= '0;
      vld_q   <= '0;
      last_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arm) begin
            state_q <= StRead;
            rcnt_q  <= '0;
          end
        end
        StRead: begin
          // rcnt wraps to 0 after LastAddr, so a same-cycle re-arm needs no reload.
          rcnt_q <= rcnt_q + 1'b1;
          if ((rcnt_q == LastAddr) && !arm) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      vld_q[0]  <= rd_en;
      last_q[0] <= rd_last;
      for (int i = 1; i < DELAY_BRAM; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  ntt_reorder_bank #(
    .WIDTH  (LOGQ),
    .AW     (LOGN + 1),
    .LATENCY(DELAY_BRAM)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_en),
    .waddr_i({wsel_q, waddr}),
    .wdata_i(in_data),
    .re_i   (rd_en),
    .raddr_i({~wsel_q, rcnt_q}),
    .rdata_o(out_data)
  );

  assign out_valid = vld_q[DELAY_BRAM-1];
  assign out_last  = last_q[DELAY_BRAM-1];
  assign busy      = (wcnt_q != '0) | rd_en | (|vld_q);

endmodule

// File: tb/tb_ntt_bitrev_reorder.sv
// Bench for ntt_bitrev_reorder (LOGN=3, LOGQ=16, DELAY_BRAM=1): directed table and
// sequences plus a randomized run against a block-level reference model.
// Define NTT_REORDER_BYPASS_EN to also exercise the bypass input.
module tb_ntt_bitrev_reorder;

  localparam int LOGN = 3;
  localparam int LOGQ = 16;
  localparam int D    = 1;
  localparam int N    = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [LOGQ-1:0] in_data;
  logic            out_valid;
  logic [LOGQ-1:0] out_data;
  logic            out_last;
  logic            busy;
`ifdef NTT_REORDER_BYPASS_EN
  logic            bypass;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  ntt_bitrev_reorder #(
    .LOGQ      (LOGQ),
    .LOGN      (LOGN),
    .DELAY_BRAM(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
`ifdef NTT_REORDER_BYPASS_EN
    .bypass   (bypass),
`endif
    .out_valid(out_valid),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int bitrev(input int k);
    int r = 0;
    for (int i = 0; i < LOGN; i++) begin
      if (((k >> i) & 1) != 0) r += 1 << (LOGN - 1 - i);
    end
    return r;
  endfunction

  // Reference model: collect whole blocks, then schedule the expected output stream.
  int              cnt = 0;
  logic [LOGQ-1:0] blk [N];
  bit              blk_byp;
  bit              exp_v [int];
  logic [LOGQ-1:0] exp_d [int];
  bit              exp_l [int];
  bit              exp_b [int];

  always @(posedge clk) begin
    if (rst) begin
      cnt = 0;
      for (int k = cyc + 1; k < cyc + 64; k++) begin
        if (exp_v.exists(k)) exp_v.delete(k);
        if (exp_d.exists(k)) exp_d.delete(k);
        if (exp_l.exists(k)) exp_l.delete(k);
        if (exp_b.exists(k)) exp_b.delete(k);
      end
    end else if (in_valid) begin
`ifdef NTT_REORDER_BYPASS_EN
      if (cnt == 0) blk_byp = bypass;
`else
      if (cnt == 0) blk_byp = 1'b0;
`endif
      blk[cnt] = in_data;
      cnt++;
      if (cnt == N) begin
        cnt = 0;
        for (int j = 0; j < N; j++) begin
          exp_v[cyc + 1 + D + j] = 1'b1;
          exp_d[cyc + 1 + D + j] = blk_byp ? blk[j] : blk[bitrev(j)];
          exp_l[cyc + 1 + D + j] = (j == N - 1);
        end
        for (int k = cyc + 1; k <= cyc + N + D; k++) exp_b[k] = 1'b1;
      end
    end
    cyc++;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("sb_valid", out_valid, exp_v.exists(cyc));
      if (exp_v.exists(cyc)) begin
        chk("sb_data", out_data, exp_d[cyc]);
        chk("sb_last", out_last, exp_l[cyc]);
      end else begin
        chk("sb_last_idle", out_last, 0);
      end
      chk("sb_busy", busy, (cnt != 0) || exp_b.exists(cyc));
    end
  end

  typedef struct {
    int              c;
    logic [LOGQ-1:0] d;
    logic            l;
  } cap_t;
  cap_t cap[$];

  // Log every emitted coefficient with its cycle for the directed sequences.
  always @(negedge clk) begin
    if (mon_en && out_valid === 1'b1) cap.push_back('{c: cyc, d: out_data, l: out_last});
  end

  task automatic drive(input logic v, input logic [LOGQ-1:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_cap(input string name, input logic [LOGQ-1:0] e[$]);
    chk({name, "_count"}, cap.size(), e.size());
    for (int i = 0; i < e.size() && i < cap.size(); i++) begin
      chk({name, "_data"}, cap[i].d, e[i]);
      chk({name, "_last"}, cap[i].l, (i % N) == N - 1);
      chk({name, "_gapfree"}, cap[i].c, cap[0].c + i);
    end
  endtask

  typedef struct {
    logic [LOGQ-1:0] din;
    logic [LOGQ-1:0] dout;
    logic            last;
  } vec_t;

  initial begin
    vec_t            tbl [N];
    int              order [N];
    logic [LOGQ-1:0] e[$];
    int              t_last;

    order = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int i = 0; i < N; i++) begin
      tbl[i].din  = LOGQ'(i);
      tbl[i].dout = LOGQ'(order[i]);
      tbl[i].last = (i == N - 1);
    end

    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef NTT_REORDER_BYPASS_EN
    bypass   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_last", out_last, 0);
    chk("reset_data", out_data, 0);
    chk("reset_busy", busy, 0);
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Basic ordering and latency, table driven.
    cap.delete();
    for (int i = 0; i < N; i++) begin
      t_last = cyc;
      drive(1'b1, tbl[i].din);
    end
    idle(14);
    chk("order_count", cap.size(), N);
    for (int i = 0; i < N && i < cap.size(); i++) begin
      chk("order_data", cap[i].d, tbl[i].dout);
      chk("order_last", cap[i].l, tbl[i].last);
      chk("order_cycle", cap[i].c, t_last + 2 + i);
    end

    // Back-to-back blocks.
    cap.delete();
    for (int i = 0; i < 2 * N; i++) drive(1'b1, LOGQ'(i));
    idle(14);
    e = '{0, 4, 2, 6, 1, 5, 3, 7, 8, 12, 10, 14, 9, 13, 11, 15};
    check_cap("b2b", e);

    // Input gaps of 3 cycles after each sample.
    cap.delete();
    for (int i = 0; i < N; i++) begin
      t_last = cyc;
      drive(1'b1, LOGQ'(i));
      idle(3);
    end
    idle(12);
    e = '{0, 4, 2, 6, 1, 5, 3, 7};
    check_cap("gaps", e);
    if (cap.size() > 0) chk("gaps_latency", cap[0].c, t_last + 2);

    // Reset mid-block with in_valid high during the reset cycle.
    cap.delete();
    for (int i = 0; i < 5; i++) drive(1'b1, LOGQ'(100 + i));
    rst = 1'b1;
    drive(1'b1, 16'd99);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_data", out_data, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) drive(1'b1, LOGQ'(i));
    idle(14);
    check_cap("rst_mid", e);

`ifdef NTT_REORDER_BYPASS_EN
    // Bypass block followed directly by a reordered block.
    cap.delete();
    bypass = 1'b1;
    for (int i = 0; i < N; i++) begin
      t_last = cyc;
      drive(1'b1, LOGQ'(i));
      bypass = 1'b0;
    end
    for (int i = N; i < 2 * N; i++) drive(1'b1, LOGQ'(i));
    idle(14);
    e = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 12, 10, 14, 9, 13, 11, 15};
    check_cap("bypass", e);
    if (cap.size() > 0) chk("bypass_latency", cap[0].c, t_last + 2);
`endif

    // Randomized traffic with occasional resets, checked by the model.
    repeat (800) begin
      rst = ($urandom_range(0, 199) == 0);
`ifdef NTT_REORDER_BYPASS_EN
      bypass = 1'($urandom_range(0, 1));
`endif
      drive($urandom_range(0, 3) != 0, LOGQ'($urandom));
    end
    rst = 1'b0;
    idle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
